// File: rtl/button_debounce_if.sv
// Button debouncer bus: raw active-low pins in, debounced level and
// one-cycle press/release event pulses out, one bit per button.
// The debouncer uses the slave modport; whoever drives the pins and consumes
// the events uses the master modport.
interface button_debounce_if #(
    parameter int NUM_BUTTONS = 3
);
    logic [NUM_BUTTONS-1:0] button_i;   // raw pins, active-low, asynchronous
    logic [NUM_BUTTONS-1:0] pressed_o;  // debounced level, 1 = held
    logic [NUM_BUTTONS-1:0] press_o;    // pulse on accepted press (and auto-repeat)
    logic [NUM_BUTTONS-1:0] release_o;  // pulse on accepted release

    modport master (
        output button_i,
        input  pressed_o,
        input  press_o,
        input  release_o
    );

    modport slave (
        input  button_i,
        output pressed_o,
        output press_o,
        output release_o
    );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: per-button two-flop synchronizer, debounce counter and
// edge detector turning bouncing active-low pins into clean active-high
// levels plus one-cycle press/release pulses.
// Optional feature macro: BUTTON_REPEAT_EN adds auto-repeat press pulses
// while a button stays held (first after REPEAT_DELAY_MS, then every
// REPEAT_RATE_MS). Without it press_o fires once per accepted press.
module button_debounce #(
    parameter int NUM_BUTTONS     = 3,
    parameter int CLOCK_HZ        = 12_000_000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    button_debounce_if.slave        bus
);

    localparam int DEB_CYC = CLOCK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DEB_W   = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    if (DEB_CYC < 2) begin : g_bad_debounce
        $error("button_debounce: debounce period must be at least 2 clock cycles");
    end

`ifdef BUTTON_REPEAT_EN
    localparam int DLY_CYC  = CLOCK_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int RATE_CYC = CLOCK_HZ / 1000 * REPEAT_RATE_MS;
    localparam int REP_MAX  = (DLY_CYC > RATE_CYC) ? DLY_CYC : RATE_CYC;
    localparam int REP_W    = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(DLY_CYC - 1);
    localparam logic [REP_W-1:0] RATE_LAST = REP_W'(RATE_CYC - 1);

    if (DLY_CYC < 2 || RATE_CYC < 2) begin : g_bad_repeat
        $error("button_debounce: repeat delay and rate must be at least 2 clock cycles");
    end
`else
    // Repeat timing is unused here, but a negative duration is still nonsense.
    if (REPEAT_DELAY_MS < 0 || REPEAT_RATE_MS < 0) begin : g_bad_repeat
        $error("button_debounce: repeat durations must not be negative");
    end
`endif

    logic [NUM_BUTTONS-1:0] w_stable;
    logic [NUM_BUTTONS-1:0] w_press;
    logic [NUM_BUTTONS-1:0] w_release;

    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
        logic [1:0]       r_sync;     // [0] first stage, [1] synchronized pin
        logic [DEB_W-1:0] r_deb_cnt;
        logic             r_stable;
        logic             r_press;
        logic             r_release;
        logic             w_sync;
        logic             w_differ;
        logic             w_accept;
        logic             w_rep_due;

        // Active-high view of the synchronized pin.
        assign w_sync   = ~r_sync[1];
        assign w_differ = w_sync ^ r_stable;
        // The pin has disagreed with the accepted state for DEB_CYC cycles.
        assign w_accept = w_differ && (r_deb_cnt == DEB_LAST);

        // Two-flop synchronizer; resets to the released (high) pin level.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= 2'b11;
            end else begin
                r_sync <= {r_sync[0], bus.button_i[b]};
            end
        end

        // Debounce counter: any agreement restarts timing, acceptance toggles state.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_deb_cnt <= {DEB_W{1'b0}};
                r_stable  <= 1'b0;
            end else if (w_accept) begin
                r_deb_cnt <= {DEB_W{1'b0}};
                r_stable  <= ~r_stable;
            end else if (w_differ) begin
                r_deb_cnt <= r_deb_cnt + {{(DEB_W-1){1'b0}}, 1'b1};
            end else begin
                r_deb_cnt <= {DEB_W{1'b0}};
            end
        end

`ifdef BUTTON_REPEAT_EN
        logic [REP_W-1:0] r_rep_cnt;
        logic             r_rep_rate;  // 0: waiting initial delay, 1: steady rate

        // Due while held and not being released this same cycle.
        assign w_rep_due = r_stable && !w_accept &&
                           (r_rep_cnt == (r_rep_rate ? RATE_LAST : DLY_LAST));

        // Repeat timer: idle while released, restarts on every press and repeat.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_rep_cnt  <= {REP_W{1'b0}};
                r_rep_rate <= 1'b0;
            end else if (!r_stable || w_accept) begin
                r_rep_cnt  <= {REP_W{1'b0}};
                r_rep_rate <= 1'b0;
            end else if (w_rep_due) begin
                r_rep_cnt  <= {REP_W{1'b0}};
                r_rep_rate <= 1'b1;
            end else begin
                r_rep_cnt  <= r_rep_cnt + {{(REP_W-1){1'b0}}, 1'b1};
            end
        end
`else
        assign w_rep_due = 1'b0;
`endif

        // Event pulses registered on the same edge that the level toggles.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= (w_accept && !r_stable) || w_rep_due;
                r_release <= w_accept && r_stable;
            end
        end

        assign w_stable[b]  = r_stable;
        assign w_press[b]   = r_press;
        assign w_release[b] = r_release;
    end

    assign bus.pressed_o = w_stable;
    assign bus.press_o   = w_press;
    assign bus.release_o = w_release;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEB_CYC=16, DLY_CYC=64, RATE_CYC=16.
// Pins are driven on the falling edge; a pin change made in the half cycle
// after posedge k is reported on posedge k+18, so 17 negedges later the
// level is still old and at the 18th negedge it is new.
module tb_button_debounce;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;
    int press_cnt [3];
    int release_cnt [3];

    button_debounce_if #(.NUM_BUTTONS(3)) bus ();

    button_debounce #(
        .NUM_BUTTONS     (3),
        .CLOCK_HZ        (16000),
        .DEBOUNCE_MS     (1),
        .REPEAT_DELAY_MS (4),
        .REPEAT_RATE_MS  (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters used to prove the absence of unwanted events.
    always @(negedge clk) begin
        for (int b = 0; b < 3; b++) begin
            if (bus.press_o[b])   press_cnt[b]   <= press_cnt[b] + 1;
            if (bus.release_o[b]) release_cnt[b] <= release_cnt[b] + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        int p1;
        int r0;
        int bad;
        int exp_pulses;
        logic exp_bit;

        n_checks = 0;
        n_fail   = 0;
        for (int b = 0; b < 3; b++) begin
            press_cnt[b]   = 0;
            release_cnt[b] = 0;
        end
        reset        = 1'b1;
        bus.button_i = 3'b111;

        // Reset state
        wait_neg(3);
        check_val("rst_pressed", {29'd0, bus.pressed_o}, 32'd0);
        check_val("rst_pulses", {26'd0, bus.press_o, bus.release_o}, 32'd0);
        reset = 1'b0;
        p0 = press_cnt[0] + press_cnt[1] + press_cnt[2];
        r0 = release_cnt[0] + release_cnt[1] + release_cnt[2];
        wait_neg(100);
        check_val("idle_pressed", {29'd0, bus.pressed_o}, 32'd0);
        check_val("idle_press_cnt", press_cnt[0] + press_cnt[1] + press_cnt[2] - p0, 32'd0);
        check_val("idle_rel_cnt", release_cnt[0] + release_cnt[1] + release_cnt[2] - r0, 32'd0);

        // Clean press on bit 0
        bus.button_i = 3'b110;
        wait_neg(17);
        check_val("press0_early", {29'd0, bus.pressed_o}, 32'd0);
        wait_neg(1);
        check_val("press0_level", {29'd0, bus.pressed_o}, 32'd1);
        check_val("press0_pulse", {29'd0, bus.press_o}, 32'd1);
        check_val("press0_norel", {29'd0, bus.release_o}, 32'd0);
        wait_neg(1);
        check_val("press0_1cyc", {29'd0, bus.press_o}, 32'd0);
        bus.button_i = 3'b111;
        wait_neg(18);
        check_val("rel0_pulse", {29'd0, bus.release_o}, 32'd1);
        wait_neg(5);

        // Bounce rejection on bit 1: 10 low, 3 high, 15 low, then high
        p1 = press_cnt[1];
        bus.button_i = 3'b101; wait_neg(10);
        bus.button_i = 3'b111; wait_neg(3);
        bus.button_i = 3'b101; wait_neg(15);
        bus.button_i = 3'b111; wait_neg(30);
        check_val("bounce_level", {29'd0, bus.pressed_o}, 32'd0);
        check_val("bounce_pulses", press_cnt[1] - p1, 32'd0);
        bus.button_i = 3'b101;
        wait_neg(17);
        check_val("bounce_hold_early", {29'd0, bus.pressed_o}, 32'd0);
        wait_neg(1);
        check_val("bounce_hold_pulse", {29'd0, bus.press_o}, 32'd2);
        check_val("bounce_hold_level", {29'd0, bus.pressed_o}, 32'd2);
        bus.button_i = 3'b111;
        wait_neg(25);

        // Release of held bit 2
        bus.button_i = 3'b011;
        wait_neg(20);
        check_val("rel2_held", {29'd0, bus.pressed_o}, 32'd4);
        bus.button_i = 3'b111;
        wait_neg(17);
        check_val("rel2_early", {29'd0, bus.release_o}, 32'd0);
        wait_neg(1);
        check_val("rel2_pulse", {29'd0, bus.release_o}, 32'd4);
        check_val("rel2_level", {29'd0, bus.pressed_o}, 32'd0);
        wait_neg(1);
        check_val("rel2_1cyc", {29'd0, bus.release_o}, 32'd0);
        wait_neg(5);

        // Simultaneous press and release of all buttons
        bus.button_i = 3'b000;
        wait_neg(18);
        check_val("all_press", {29'd0, bus.press_o}, 32'd7);
        bus.button_i = 3'b111;
        wait_neg(18);
        check_val("all_release", {29'd0, bus.release_o}, 32'd7);
        wait_neg(5);

        // Asynchronous reset while bit 0 held and bits 1,2 mid-debounce
        bus.button_i = 3'b110;
        wait_neg(18);
        check_val("pre_rst_level", {29'd0, bus.pressed_o}, 32'd1);
        wait_neg(2);
        bus.button_i = 3'b000;
        wait_neg(8);
        reset = 1'b1;
        #1;
        check_val("rst_async_level", {29'd0, bus.pressed_o}, 32'd0);
        wait_neg(2);
        reset = 1'b0;
        p0 = press_cnt[0] + press_cnt[1] + press_cnt[2];
        wait_neg(17);
        check_val("post_rst_early", {29'd0, bus.pressed_o}, 32'd0);
        check_val("post_rst_nopulse", press_cnt[0] + press_cnt[1] + press_cnt[2] - p0, 32'd0);
        wait_neg(1);
        check_val("post_rst_press", {29'd0, bus.press_o}, 32'd7);
        bus.button_i = 3'b111;
        wait_neg(25);

        // Long hold on bit 0: auto-repeat pattern when enabled, single pulse otherwise
        bus.button_i = 3'b110;
        wait_neg(18);
        p0  = press_cnt[0];
        bad = 0;
        for (int off = 0; off < 200; off++) begin
`ifdef BUTTON_REPEAT_EN
            exp_bit = (off == 0) || (off >= 64 && ((off - 64) % 16) == 0);
`else
            exp_bit = (off == 0);
`endif
            if (bus.press_o[0] !== exp_bit) bad++;
            @(negedge clk);
        end
`ifdef BUTTON_REPEAT_EN
        exp_pulses = 10;
`else
        exp_pulses = 1;
`endif
        check_val("hold_pattern_bad", bad, 32'd0);
        check_val("hold_pulse_cnt", press_cnt[0] - p0, exp_pulses);
        bus.button_i = 3'b111;
        wait_neg(18);
        check_val("hold_rel_pulse", {29'd0, bus.release_o}, 32'd1);
        check_val("hold_rel_nopress", {31'd0, bus.press_o[0]}, 32'd0);
        p0 = press_cnt[0];
        wait_neg(100);
        check_val("after_rel_quiet", press_cnt[0] - p0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
